gate_checker: RTL

//   Stimulus/response end of the gate interface: drives io_A/io_B into an external gate DUT,

---
 rtl/gate_checker_pkg.sv | 36 +++
 rtl/gate_chk_pipe.sv | 64 ++++++
 rtl/gate_checker.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/gate_checker_pkg.sv
// -----------------------------------------------------------------------------
// gate_checker_pkg
//   Shared definitions for the gate checker: golden-function encodings, the
//   checker FSM state type and the golden evaluation function.
//   No ports (package).
// -----------------------------------------------------------------------------
package gate_checker_pkg;

   localparam logic [1:0] OP_AND  = 2'd0;
   localparam logic [1:0] OP_OR   = 2'd1;
   localparam logic [1:0] OP_XOR  = 2'd2;
   localparam logic [1:0] OP_NAND = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Golden bitwise function at the widest legal operand size; callers
   // zero-extend their operands and keep the low WIDTH bits of the result.
   function automatic logic [7:0] op_eval(input logic [1:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
      logic [7:0] r;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         default: r = ~(a & b);
      endcase
      return r;
   endfunction

endpackage

// File: rtl/gate_chk_pipe.sv
// -----------------------------------------------------------------------------
// gate_chk_pipe
//   LAT-deep delay line carrying {valid, payload} so that the expected value
//   of a pattern arrives at the compare point in the same cycle the external
//   DUT presents its response. With LAT=0 the line is a pure wire.
// Ports
//   clock    in   1    rising-edge clock
//   reset    in   1    synchronous active-high reset, clears valid bits
//   i_valid  in   1    push qualifier
//   i_data   in   DW   payload pushed this cycle
//   o_valid  out  1    tail entry valid
//   o_data   out  DW   tail entry payload
// -----------------------------------------------------------------------------
module gate_chk_pipe #(
   parameter int LAT = 0,
   parameter int DW  = 3
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          i_valid,
   input  logic [DW-1:0] i_data,
   output logic          o_valid,
   output logic [DW-1:0] o_data
);

   generate
      if (LAT == 0) begin : g_bypass
         // Clock and reset have no role without storage.
         logic w_unused;
         assign w_unused = ^{clock, reset};
         assign o_valid  = i_valid;
         assign o_data   = i_data;
      end else begin : g_shift
         logic [LAT-1:0] r_valid;
         logic [DW-1:0]  r_data [LAT];

         for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
               always_ff @(posedge clock) begin
                  if (reset) begin
                     r_valid[gi] <= 1'b0;
                  end else begin
                     r_valid[gi] <= i_valid;
                  end
                  r_data[gi] <= i_data;
               end
            end else begin : g_body
               always_ff @(posedge clock) begin
                  if (reset) begin
                     r_valid[gi] <= 1'b0;
                  end else begin
                     r_valid[gi] <= r_valid[gi-1];
                  end
                  r_data[gi] <= r_data[gi-1];
               end
            end
         end

         assign o_valid = r_valid[LAT-1];
         assign o_data  = r_data[LAT-1];
      end
   endgenerate

endmodule

// File: rtl/gate_checker.sv
// -----------------------------------------------------------------------------
// gate_checker
//   Drives every operand pair {io_A,io_B} into an external gate, compares the
//   returned io_Y against the golden function selected by io_op and reports
//   pass/fail, a saturating mismatch count and the index of the first failing
//   pattern. One exhaustive sweep of N = 2^(2*WIDTH) patterns per start.
// Ports
//   clock        in   1        rising-edge clock
//   reset        in   1        synchronous active-high reset
//   io_start     in   1        begin a sweep (honoured only in IDLE)
//   io_op        in   2        golden function, latched at start
//   io_A         out  WIDTH    operand A (upper half of pattern index)
//   io_B         out  WIDTH    operand B (lower half of pattern index)
//   io_Y         in   WIDTH    response of the gate under test
//   io_busy      out  1        sweep or drain in progress
//   io_done      out  1        one-cycle end-of-sweep pulse
//   io_pass      out  1        sweep had zero mismatches
//   io_errCount  out  ERR_W    saturating mismatch count
//   io_failIdx   out  2*WIDTH  index of first mismatching pattern
// -----------------------------------------------------------------------------
module gate_checker
   import gate_checker_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int LAT   = 0,
   parameter int ERR_W = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               io_start,
   input  logic [1:0]         io_op,
   output logic [WIDTH-1:0]   io_A,
   output logic [WIDTH-1:0]   io_B,
   input  logic [WIDTH-1:0]   io_Y,
   output logic               io_busy,
   output logic               io_done,
   output logic               io_pass,
   output logic [ERR_W-1:0]   io_errCount,
   output logic [2*WIDTH-1:0] io_failIdx
);

   localparam int                IW         = 2 * WIDTH;
   localparam int                DW         = WIDTH + IW;
   localparam logic [IW-1:0]     CNT_LAST   = '1;
   localparam logic [ERR_W-1:0]  ERR_MAX    = '1;
   localparam logic [2:0]        DRAIN_LAST = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

   state_t           r_state;
   state_t           w_state_next;
   logic [IW-1:0]    r_cnt;
   logic [2:0]       r_drain;
   logic [1:0]       r_op;
   logic [ERR_W-1:0] r_err;
   logic [ERR_W-1:0] w_err_next;
   logic [IW-1:0]    r_fail;
   logic [IW-1:0]    w_fail_next;
   logic             r_pass;

   logic [7:0]       w_a_ext;
   logic [7:0]       w_b_ext;
   logic [7:0]       w_eval;
   logic [WIDTH-1:0] w_exp;
   logic             w_push;
   logic             w_tail_valid;
   logic [DW-1:0]    w_tail_data;
   logic [WIDTH-1:0] w_tail_exp;
   logic [IW-1:0]    w_tail_idx;
   logic             w_mismatch;

   // ---------------------------------------------------------------- outputs
   assign io_A        = (r_state == ST_RUN) ? r_cnt[IW-1:WIDTH] : '0;
   assign io_B        = (r_state == ST_RUN) ? r_cnt[WIDTH-1:0]  : '0;
   assign io_busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign io_done     = (r_state == ST_DONE);
   assign io_pass     = r_pass;
   assign io_errCount = r_err;
   assign io_failIdx  = r_fail;

   // ------------------------------------------------------- golden function
   always_comb begin
      w_a_ext = '0;
      w_b_ext = '0;
      w_a_ext[WIDTH-1:0] = r_cnt[IW-1:WIDTH];
      w_b_ext[WIDTH-1:0] = r_cnt[WIDTH-1:0];
   end

   assign w_eval = op_eval(r_op, w_a_ext, w_b_ext);
   assign w_exp  = w_eval[WIDTH-1:0];
   assign w_push = (r_state == ST_RUN);

   // Expected value travels with its pattern index so a late compare can
   // still name the pattern that failed.
   gate_chk_pipe #(
      .LAT (LAT),
      .DW  (DW)
   ) u_pipe (
      .clock   (clock),
      .reset   (reset),
      .i_valid (w_push),
      .i_data  ({w_exp, r_cnt}),
      .o_valid (w_tail_valid),
      .o_data  (w_tail_data)
   );

   assign w_tail_exp = w_tail_data[DW-1:IW];
   assign w_tail_idx = w_tail_data[IW-1:0];
   assign w_mismatch = (w_tail_exp != io_Y);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (io_start) begin
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (r_cnt == CNT_LAST) begin
               w_state_next = (LAT == 0) ? ST_DONE : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (r_drain == DRAIN_LAST) begin
               w_state_next = ST_DONE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------- result bookkeeping
   // The error count only leaves zero on the first mismatch of a sweep, so
   // a zero count doubles as the "no failure captured yet" flag.
   always_comb begin
      w_err_next  = r_err;
      w_fail_next = r_fail;
      if ((r_state == ST_IDLE) && io_start) begin
         w_err_next  = '0;
         w_fail_next = '0;
      end else if (w_tail_valid && w_mismatch) begin
         if (r_err != ERR_MAX) begin
            w_err_next = r_err + 1'b1;
         end
         if (r_err == '0) begin
            w_fail_next = w_tail_idx;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt   <= '0;
         r_drain <= '0;
         r_op    <= OP_AND;
         r_err   <= '0;
         r_fail  <= '0;
         r_pass  <= 1'b0;
      end else begin
         r_err  <= w_err_next;
         r_fail <= w_fail_next;

         case (r_state)
            ST_IDLE: begin
               if (io_start) begin
                  r_op   <= io_op;
                  r_cnt  <= '0;
                  r_pass <= 1'b0;
               end
            end
            ST_RUN: begin
               r_drain <= '0;
               if (r_cnt != CNT_LAST) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DRAIN: begin
               r_drain <= r_drain + 1'b1;
            end
            default: begin
            end
         endcase

         // The final compare lands on the same edge that enters DONE, so the
         // verdict is taken from the post-compare count.
         if ((w_state_next == ST_DONE) && (r_state != ST_DONE)) begin
            r_pass <= (w_err_next == '0);
         end
      end
   end

endmodule
